// File: rtl/mem_access_pkg.sv
// mem_access_pkg: opcodes, bus size encoding and FSM states shared by the memory stage.
package mem_access_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  function automatic size_t op_size(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? SZ_WORD :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_BYTE;
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: picks the addressed lane of a raw read word and sign/zero extends it.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = raw[8*off +: 8];
  assign h = off[1] ? raw[31:16] : raw[15:0];
  assign data = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : raw;
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage issuing one SRAM-like bus transaction per load/store and stalling until it completes.
// Defining MEM_ACCESS_PERF_EN adds stall-cycle and accepted-request counters.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [5:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_wdata,
  input  logic              in_rm,
  input  logic              in_wm,
  input  logic              in_flush,
  output logic              stall,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [ADDR_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [ADDR_W-1:0] dresp_data,
  output logic              load_ok,
  output logic [ADDR_W-1:0] rdata,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_req_cnt
`endif
);
  state_t            state;
  size_t             sz;
  logic [5:0]        op_q;
  logic              ld_q, kill, busy, in_ok, mem_op, fault, accept;
  logic [ADDR_W-1:0] raw, aligned;
  assign busy     = state == REQ || state == WAIT;
  assign in_ok    = in_valid & resetn & ~in_flush;
  assign mem_op   = in_rm | in_wm;
  assign sz       = op_size(in_op);
  assign fault    = mem_op & (sz == SZ_WORD ? |in_addr[1:0] : sz == SZ_HALF & in_addr[0]);
  assign accept   = in_ok & mem_op & ~fault & ~busy;
  assign stall    = accept | busy;
  assign adel     = in_ok & in_rm & fault & ~busy;
  assign ades     = in_ok & in_wm & fault & ~busy;
  assign badvaddr = (adel | ades) ? in_addr : '0;
  assign dreq_valid = state == REQ;
  assign load_ok  = state == DONE & ld_q & ~kill;
  assign rdata    = load_ok ? aligned : '0;
  mem_access_load_align u_align (
    .op  (op_q),
    .off (dreq_addr[1:0]),
    .raw (raw),
    .data(aligned)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op_q        <= '0;
      ld_q        <= 1'b0;
      kill        <= 1'b0;
      raw         <= '0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
    end else begin
      unique case (state)
        REQ:     if (dresp_addr_ok) state <= dresp_data_ok ? DONE : WAIT;
        WAIT:    if (dresp_data_ok) state <= DONE;
        default: state <= accept ? REQ : IDLE;
      endcase
      // a flushed transaction still finishes its handshake; kill only hides the result
      kill <= busy & (kill | in_flush);
      if (busy & dresp_data_ok & (state == WAIT | dresp_addr_ok)) raw <= dresp_data;
      if (accept) begin
        op_q        <= in_op;
        ld_q        <= in_rm;
        dreq_addr   <= in_addr;
        dreq_size   <= sz;
        dreq_strobe <= in_wm ? (sz == SZ_WORD ? 4'hF : (sz == SZ_HALF ? 4'h3 : 4'h1) << in_addr[1:0]) : 4'h0;
        dreq_data   <= sz == SZ_WORD ? in_wdata : sz == SZ_HALF ? {2{in_wdata[15:0]}} : {4{in_wdata[7:0]}};
      end
    end
  end
`ifdef MEM_ACCESS_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_req_cnt   <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(stall);
      perf_req_cnt   <= perf_req_cnt + 32'(accept);
    end
  end
`endif
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed transactions checked every cycle against a transaction-level model plus literal expectations.
module tb_mem_access;
  logic        clk = 0, resetn = 0;
  logic        in_valid = 0, in_rm = 0, in_wm = 0, in_flush = 0;
  logic [5:0]  in_op = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        dresp_addr_ok = 0, dresp_data_ok = 0;
  logic [31:0] dresp_data = 0;
  logic        stall, dreq_valid, load_ok, adel, ades;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_addr, dreq_data, rdata, badvaddr;
  int checks = 0, errors = 0;

  mem_access dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rm(in_rm), .in_wm(in_wm), .in_flush(in_flush), .stall(stall),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .load_ok(load_ok),
    .rdata(rdata), .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      6'h23, 6'h2B:        return 4;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] off, input logic [31:0] raw);
    int nb;
    logic [31:0] mask, v;
    nb = nbytes(op);
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
    v = (raw >> (8 * int'(off))) & mask;
    if ((op == 6'h20 || op == 6'h21) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // transaction-level model: at most one outstanding access, plus one just-finished result
  typedef struct packed {
    logic [5:0]  op;
    logic        ld, st, killed, taken;
    logic [31:0] addr, wdata;
  } txn_t;
  txn_t cur = '0, nxt, done = '0;
  logic m_busy = 0, m_done = 0, flt, acc, fin;
  logic [31:0] done_raw = 0;
  logic        e_req, e_lok, e_adel, e_ades;
  logic [31:0] e_bad, e_data, e_rdata, sm;
  logic [3:0]  e_strobe;
  logic [1:0]  e_size;

  always_comb begin
    nxt = cur;
    nxt.killed = cur.killed | in_flush;
    nxt.taken = cur.taken | dresp_addr_ok;
    fin = m_busy && nxt.taken && dresp_data_ok;
    flt = (in_rm || in_wm) && (int'(in_addr[1:0]) % nbytes(in_op) != 0);
    acc = in_valid && resetn && !in_flush && !m_busy && (in_rm || in_wm) && !flt;
    e_adel = in_valid && resetn && !in_flush && !m_busy && in_rm && flt;
    e_ades = in_valid && resetn && !in_flush && !m_busy && in_wm && flt;
    e_bad = (e_adel || e_ades) ? in_addr : 32'h0;
    e_req = m_busy && !cur.taken;
    e_lok = m_done && done.ld && !done.killed;
    e_size = nbytes(cur.op) == 4 ? 2'd2 : nbytes(cur.op) == 2 ? 2'd1 : 2'd0;
    sm = ((32'h1 << nbytes(cur.op)) - 1) << cur.addr[1:0];
    e_strobe = cur.st ? sm[3:0] : 4'h0;
    e_data = nbytes(cur.op) == 4 ? cur.wdata :
             nbytes(cur.op) == 2 ? (cur.wdata & 32'hFFFF) * 32'h0001_0001 : (cur.wdata & 32'hFF) * 32'h0101_0101;
    e_rdata = extract(done.op, done.addr[1:0], done_raw);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0;
      m_done <= 0;
    end else begin
      m_done <= fin;
      if (fin) begin
        done <= nxt;
        done_raw <= dresp_data;
      end
      m_busy <= acc || (m_busy && !fin);
      if (acc) cur <= '{op: in_op, ld: in_rm, st: in_wm, killed: 1'b0, taken: 1'b0, addr: in_addr, wdata: in_wdata};
      else if (m_busy) cur <= nxt;
    end
  end

  // observation counters used by the literal expectations
  int mon_stall = 0, mon_lok = 0, mon_req = 0, mon_adel = 0, mon_ades = 0;
  logic [31:0] last_rdata = 0, last_data = 0, last_bad = 0;
  logic [3:0]  last_strobe = 0;
  logic [1:0]  last_size = 0;

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(acc || m_busy));
    chk("dreq_valid", 32'(dreq_valid), 32'(e_req));
    chk("load_ok", 32'(load_ok), 32'(e_lok));
    chk("adel", 32'(adel), 32'(e_adel));
    chk("ades", 32'(ades), 32'(e_ades));
    chk("badvaddr", badvaddr, e_bad);
    if (e_req) begin
      chk("dreq_addr", dreq_addr, cur.addr);
      chk("dreq_size", 32'(dreq_size), 32'(e_size));
      chk("dreq_strobe", 32'(dreq_strobe), 32'(e_strobe));
      chk("dreq_data", dreq_data, e_data);
    end
    if (e_lok) chk("rdata", rdata, e_rdata);
    mon_stall += int'(stall);
    mon_req += int'(dreq_valid);
    mon_adel += int'(adel);
    mon_ades += int'(ades);
    if (load_ok) begin mon_lok++; last_rdata = rdata; end
    if (dreq_valid) begin last_strobe = dreq_strobe; last_data = dreq_data; last_size = dreq_size; end
    if (adel || ades) last_bad = badvaddr;
  end

  int s_stall, s_lok, s_req, s_adel, s_ades;
  task automatic snap();
    s_stall = mon_stall; s_lok = mon_lok; s_req = mon_req; s_adel = mon_adel; s_ades = mon_ades;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic txn(input logic [5:0] op, input logic rm, input logic wm, input logic [31:0] addr,
                     input logic [31:0] wdata, input int a_dly, input int d_dly,
                     input logic [31:0] raw, input int flush_at);
    in_valid = 1; in_op = op; in_rm = rm; in_wm = wm; in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    in_valid = 0; in_rm = 0; in_wm = 0;
    for (int c = 0; c <= a_dly + d_dly; c++) begin
      dresp_addr_ok = (c == a_dly);
      dresp_data_ok = (c == a_dly + d_dly);
      dresp_data = raw;
      in_flush = (c == flush_at);
      @(posedge clk); #1;
    end
    dresp_addr_ok = 0; dresp_data_ok = 0; in_flush = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_dreq_valid", 32'(dreq_valid), 0);
    chk("rst_load_ok", 32'(load_ok), 0);
    chk("rst_rdata", rdata, 0);
    resetn = 1;
    idle(1);

    snap();
    txn(6'h23, 1, 0, 32'h8000_0010, 0, 0, 0, 32'h1234_5678, -1); idle(2);
    chk("lw_stall_cycles", 32'(mon_stall - s_stall), 2);
    chk("lw_load_ok_count", 32'(mon_lok - s_lok), 1);
    chk("lw_rdata", last_rdata, 32'h1234_5678);

    snap();
    txn(6'h20, 1, 0, 32'h8000_0013, 0, 0, 0, 32'h80FF_FF7F, -1); idle(2);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lb_load_ok_count", 32'(mon_lok - s_lok), 1);
    txn(6'h24, 1, 0, 32'h8000_0013, 0, 0, 0, 32'h80FF_FF7F, -1); idle(2);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);

    snap();
    txn(6'h29, 0, 1, 32'h8000_0012, 32'h0000_BEEF, 0, 0, 0, -1); idle(2);
    chk("sh_strobe", 32'(last_strobe), 32'hC);
    chk("sh_data", last_data, 32'hBEEF_BEEF);
    chk("sh_size", 32'(last_size), 1);
    chk("sh_no_load_ok", 32'(mon_lok - s_lok), 0);

    snap();
    txn(6'h23, 1, 0, 32'h8000_0012, 0, 0, 0, 0, -1); idle(2);
    chk("lw_mis_adel", 32'(mon_adel - s_adel), 1);
    chk("lw_mis_badvaddr", last_bad, 32'h8000_0012);
    chk("lw_mis_no_req", 32'(mon_req - s_req), 0);
    chk("lw_mis_no_stall", 32'(mon_stall - s_stall), 0);

    snap();
    txn(6'h2B, 0, 1, 32'h8000_0031, 32'h1, 0, 0, 0, -1); idle(2);
    chk("sw_mis_ades", 32'(mon_ades - s_ades), 1);
    chk("sw_mis_badvaddr", last_bad, 32'h8000_0031);
    chk("sw_mis_no_req", 32'(mon_req - s_req), 0);

    snap();
    txn(6'h00, 0, 0, 32'h8000_0040, 0, 0, 0, 0, -1); idle(2);
    chk("nonmem_no_stall", 32'(mon_stall - s_stall), 0);
    chk("nonmem_no_req", 32'(mon_req - s_req), 0);

    snap();
    txn(6'h21, 1, 0, 32'h8000_0022, 0, 3, 2, 32'h7FFF_0000, 4); idle(2);
    chk("flush_stall_cycles", 32'(mon_stall - s_stall), 7);
    chk("flush_req_cycles", 32'(mon_req - s_req), 4);
    chk("flush_no_load_ok", 32'(mon_lok - s_lok), 0);

    snap();
    txn(6'h25, 1, 0, 32'h8000_0006, 0, 1, 1, 32'hABCD_1234, -1); idle(2);
    chk("lhu_rdata", last_rdata, 32'h0000_ABCD);
    chk("lhu_stall_cycles", 32'(mon_stall - s_stall), 4);

    snap();
    txn(6'h23, 1, 0, 32'h8000_0050, 0, 0, 0, 32'h0BAD_F00D, -1);
    txn(6'h28, 0, 1, 32'h8000_0051, 32'h5A, 0, 0, 0, -1); idle(2);
    chk("b2b_stall_cycles", 32'(mon_stall - s_stall), 4);
    chk("b2b_req_cycles", 32'(mon_req - s_req), 2);
    chk("b2b_rdata", last_rdata, 32'h0BAD_F00D);
    chk("b2b_sb_strobe", 32'(last_strobe), 32'h2);
    chk("b2b_sb_data", last_data, 32'h5A5A_5A5A);

    in_valid = 1; in_op = 6'h23; in_rm = 1; in_addr = 32'h8000_0040;
    @(posedge clk); #1;
    in_valid = 0; in_rm = 0; dresp_addr_ok = 1;
    @(posedge clk); #1;
    dresp_addr_ok = 0;
    #2 resetn = 0;
    #1;
    chk("rst_wait_stall", 32'(stall), 0);
    chk("rst_wait_dreq_valid", 32'(dreq_valid), 0);
    chk("rst_wait_load_ok", 32'(load_ok), 0);
    dresp_data_ok = 1; dresp_data = 32'hDEAD_BEEF;
    idle(1);
    dresp_data_ok = 0;
    idle(1);
    resetn = 1;
    idle(1);
    snap();
    txn(6'h23, 1, 0, 32'h8000_0044, 0, 0, 0, 32'hCAFE_F00D, -1); idle(2);
    chk("post_rst_load_ok", 32'(mon_lok - s_lok), 1);
    chk("post_rst_rdata", last_rdata, 32'hCAFE_F00D);
    chk("post_rst_stall_cycles", 32'(mon_stall - s_stall), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
